// File: rtl/kirby_anim_pkg.sv
// Shared action encoding, per-action frame table and sequencer state type
// for the Kirby animation sequencer.
package kirby_anim_pkg;

  typedef enum logic [2:0] {
    ACT_IDLE = 3'd0,
    ACT_WALK = 3'd1,
    ACT_JUMP = 3'd2
  } action_t;

  typedef enum logic [1:0] {
    S_LOOP = 2'd0,
    S_ONCE = 2'd1,
    S_HOLD = 2'd2
  } anim_state_t;

  localparam int         NUM_ENTRIES = 3;
  localparam logic [3:0] FRAME_NUMBER [NUM_ENTRIES] = '{4'd2, 4'd10, 4'd10};
  localparam logic [2:0] ONESHOT_MASK = 3'b100;

  // Unknown actions report a single-frame looping action so indices stay in range.
  function automatic logic [3:0] frame_last(input logic [2:0] act);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (act == 3'(i)) r = FRAME_NUMBER[i[1:0]] - 4'd1;
    end
    return r;
  endfunction

  function automatic logic is_oneshot(input logic [2:0] act);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (act == 3'(i)) r = ONESHOT_MASK[i[1:0]];
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Turns the asynchronous VSYNC-derived frame_clk into a one-Clk display tick
// and divides ticks down into animation steps.
module frame_tick_gen #(
  parameter int TICKS_PER_FRAME = 4
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  input  logic freeze,
  input  logic presc_clr,
  output logic tick,
  output logic step
);

  localparam int             PW         = $clog2(TICKS_PER_FRAME + 1);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICKS_PER_FRAME - 1);

  logic          fclk_p0, fclk_p1, fclk_p2;
  logic [PW-1:0] presc;

  // p0/p1 synchronise, p2 is the edge reference
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fclk_p0 <= 1'b0;
      fclk_p1 <= 1'b0;
      fclk_p2 <= 1'b0;
    end else begin
      fclk_p0 <= frame_clk;
      fclk_p1 <= fclk_p0;
      fclk_p2 <= fclk_p1;
    end
  end

  // A frozen edge is dropped outright, so the prescaler phase is preserved.
  assign tick = fclk_p1 & ~fclk_p2 & ~freeze;
  assign step = tick & (presc == PRESC_LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      presc <= '0;
    end else if (presc_clr) begin
      presc <= '0;
    end else if (tick) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

endmodule

// File: rtl/kirby_anim_sequencer.sv
// Chooses the playing action and its frame index for the sprite-sheet mapper;
// looping actions wrap, one-shot actions play once, hold, then hand back.
module kirby_anim_sequencer
  import kirby_anim_pkg::*;
#(
  parameter int NUM_ACTIONS     = 3,
  parameter int TICKS_PER_FRAME = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [2:0] action_req,
  input  logic       freeze,
  output logic [2:0] character_action_idx,
  output logic [3:0] character_action_frame_idx,
  output logic       anim_done,
  output logic       busy_oneshot
);

  logic        tick, step, presc_clr;

  anim_state_t state_q, state_d;
  logic [2:0]  action_q, action_d;
  logic [3:0]  frame_q, frame_d;
  logic [2:0]  pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        done_d, busy_d;

  logic        req_valid;
  logic        do_switch;
  logic [2:0]  target;
  logic [3:0]  last;

  frame_tick_gen #(
    .TICKS_PER_FRAME (TICKS_PER_FRAME)
  ) u_tick (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .freeze    (freeze),
    .presc_clr (presc_clr),
    .tick      (tick),
    .step      (step)
  );

  assign req_valid = (action_req < 3'(NUM_ACTIONS));
  assign last      = frame_last(action_q);

  // The switch decision uses this Clk's latched view, so a request arriving
  // with the tick is honoured on that tick.
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    state_d    = state_q;
    action_d   = action_q;
    frame_d    = frame_q;
    done_d     = 1'b0;
    presc_clr  = 1'b0;
    do_switch  = 1'b0;

    if (req_valid) begin
      if (action_req != action_q) begin
        pend_d     = action_req;
        pend_vld_d = 1'b1;
      end else begin
        pend_vld_d = 1'b0;
      end
    end

    target = pend_vld_d ? pend_d : 3'(ACT_IDLE);

    case (state_q)
      S_LOOP: begin
        if (tick && pend_vld_d) begin
          do_switch = 1'b1;
        end else if (step) begin
          frame_d = (frame_q == last) ? 4'd0 : frame_q + 4'd1;
        end
      end
      S_ONCE: begin
        if (step) begin
          if (frame_q == last) begin
            done_d  = 1'b1;
            state_d = S_HOLD;
          end else begin
            frame_d = frame_q + 4'd1;
          end
        end
      end
      S_HOLD: begin
        if (tick) do_switch = 1'b1;
      end
      default: state_d = S_LOOP;
    endcase

    if (do_switch) begin
      action_d   = target;
      frame_d    = 4'd0;
      presc_clr  = 1'b1;
      pend_vld_d = 1'b0;
      state_d    = is_oneshot(target) ? S_ONCE : S_LOOP;
    end

    busy_d = (state_d != S_LOOP);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_LOOP;
      action_q     <= 3'd0;
      frame_q      <= 4'd0;
      pend_q       <= 3'd0;
      pend_vld_q   <= 1'b0;
      anim_done    <= 1'b0;
      busy_oneshot <= 1'b0;
    end else begin
      state_q      <= state_d;
      action_q     <= action_d;
      frame_q      <= frame_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      anim_done    <= done_d;
      busy_oneshot <= busy_d;
    end
  end

  assign character_action_idx       = action_q;
  assign character_action_frame_idx = frame_q;

endmodule

// File: tb/tb_kirby_anim_sequencer.sv
// Scoreboard bench for kirby_anim_sequencer: each frame_clk edge pushes the
// expected action/frame/busy triple, popped and compared once the DUT settles.
module tb_kirby_anim_sequencer;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_clk;
  logic       freeze;
  logic [2:0] action_req;
  logic [2:0] character_action_idx;
  logic [3:0] character_action_frame_idx;
  logic       anim_done;
  logic       busy_oneshot;

  typedef struct {
    logic [2:0] act;
    logic [3:0] frm;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   done_base;

  kirby_anim_sequencer #(
    .NUM_ACTIONS     (3),
    .TICKS_PER_FRAME (4)
  ) dut (
    .Clk                        (Clk),
    .Reset_n                    (Reset_n),
    .frame_clk                  (frame_clk),
    .action_req                 (action_req),
    .freeze                     (freeze),
    .character_action_idx       (character_action_idx),
    .character_action_frame_idx (character_action_frame_idx),
    .anim_done                  (anim_done),
    .busy_oneshot               (busy_oneshot)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && anim_done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [2:0] req);
    Reset_n    = 1'b0;
    frame_clk  = 1'b0;
    freeze     = 1'b0;
    action_req = req;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
  endtask

  // One full frame_clk period (8 Clk). req_at_tick >= 0 is applied in the
  // very Clk the synchronised tick is present.
  task automatic frame_edge(input int req_at_tick, input logic [2:0] e_act,
                            input logic [3:0] e_frm, input logic e_busy, input string tag);
    exp_t e;
    e.act = e_act; e.frm = e_frm; e.busy = e_busy; e.tag = tag;
    sb_q.push_back(e);
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    if (req_at_tick >= 0) action_req = 3'(req_at_tick);
    repeat (2) @(negedge Clk);
    e = sb_q.pop_front();
    chk({e.tag, ".act"},  32'(character_action_idx),       32'(e.act));
    chk({e.tag, ".frm"},  32'(character_action_frame_idx), 32'(e.frm));
    chk({e.tag, ".busy"}, 32'(busy_oneshot),               32'(e.busy));
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: reset values, first step on the 4th edge, async reset mid-play
    Reset_n = 1'b0; frame_clk = 1'b0; freeze = 1'b0; action_req = 3'd0;
    repeat (2) @(negedge Clk);
    chk("rst.act",  32'(character_action_idx), 0);
    chk("rst.frm",  32'(character_action_frame_idx), 0);
    chk("rst.done", 32'(anim_done), 0);
    chk("rst.busy", 32'(busy_oneshot), 0);
    do_reset(3'd0);
    for (int k = 1; k <= 6; k++)
      frame_edge(-1, 3'd0, 4'((k / 4) % 2), 1'b0, $sformatf("T1.%0d", k));
    chk("T1.pre_rst_frm", 32'(character_action_frame_idx), 1);
    #3 Reset_n = 1'b0;
    #1;
    chk("T1.async.act", 32'(character_action_idx), 0);
    chk("T1.async.frm", 32'(character_action_frame_idx), 0);
    chk("T1.async.busy", 32'(busy_oneshot), 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    for (int k = 1; k <= 4; k++)
      frame_edge(-1, 3'd0, 4'((k / 4) % 2), 1'b0, $sformatf("T1r.%0d", k));

    // T2: looping walk wraps 9 -> 0
    do_reset(3'd0);
    done_base = done_cnt;
    action_req = 3'd1;
    frame_edge(-1, 3'd1, 4'd0, 1'b0, "T2.0");
    for (int j = 1; j <= 40; j++)
      frame_edge(-1, 3'd1, 4'((j / 4) % 10), 1'b0, $sformatf("T2.%0d", j));
    chk("T2.no_done", 32'(done_cnt - done_base), 0);

    // T3: one-shot jump, request for walk latched mid-play
    do_reset(3'd0);
    done_base = done_cnt;
    action_req = 3'd2;
    frame_edge(-1, 3'd2, 4'd0, 1'b1, "T3.0");
    for (int j = 1; j <= 41; j++) begin
      if (j <= 40)
        frame_edge(-1, 3'd2, 4'(((j / 4) > 9) ? 9 : (j / 4)), 1'b1, $sformatf("T3.%0d", j));
      else
        frame_edge(-1, 3'd1, 4'd0, 1'b0, $sformatf("T3.%0d", j));
      if (j == 5) action_req = 3'd1;
      if (j == 39) chk("T3.done_early", 32'(done_cnt - done_base), 0);
      if (j == 40) chk("T3.done_pulse", 32'(done_cnt - done_base), 1);
    end
    for (int j = 42; j <= 45; j++)
      frame_edge(-1, 3'd1, 4'(((j - 41) / 4) % 10), 1'b0, $sformatf("T3.%0d", j));
    chk("T3.done_total", 32'(done_cnt - done_base), 1);

    // T4: one-shot returns to idle when idle is requested meanwhile
    do_reset(3'd0);
    done_base = done_cnt;
    action_req = 3'd2;
    frame_edge(-1, 3'd2, 4'd0, 1'b1, "T4.0");
    for (int j = 1; j <= 41; j++) begin
      if (j <= 40)
        frame_edge(-1, 3'd2, 4'(((j / 4) > 9) ? 9 : (j / 4)), 1'b1, $sformatf("T4.%0d", j));
      else
        frame_edge(-1, 3'd0, 4'd0, 1'b0, $sformatf("T4.%0d", j));
      if (j == 2) action_req = 3'd0;
    end
    chk("T4.done_total", 32'(done_cnt - done_base), 1);

    // T5: invalid request ignored, freeze preserves phase
    do_reset(3'd0);
    action_req = 3'd1;
    frame_edge(-1, 3'd1, 4'd0, 1'b0, "T5.0");
    for (int j = 1; j <= 7; j++) begin
      frame_edge(-1, 3'd1, 4'((j / 4) % 10), 1'b0, $sformatf("T5.%0d", j));
      if (j == 5) action_req = 3'd5;
    end
    freeze = 1'b1;
    for (int f = 0; f < 8; f++)
      frame_edge(-1, 3'd1, 4'd1, 1'b0, $sformatf("T5.frz%0d", f));
    freeze = 1'b0;
    for (int j = 8; j <= 12; j++)
      frame_edge(-1, 3'd1, 4'((j / 4) % 10), 1'b0, $sformatf("T5.%0d", j));

    // T6: request arriving with the stepping tick switches instead of stepping
    do_reset(3'd0);
    action_req = 3'd1;
    frame_edge(-1, 3'd1, 4'd0, 1'b0, "T6.0");
    for (int j = 1; j <= 3; j++)
      frame_edge(-1, 3'd1, 4'd0, 1'b0, $sformatf("T6.%0d", j));
    frame_edge(0, 3'd0, 4'd0, 1'b0, "T6.coincide");
    for (int j = 1; j <= 4; j++)
      frame_edge(-1, 3'd0, 4'((j / 4) % 2), 1'b0, $sformatf("T6.after%0d", j));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
